// File: rtl/ddr_access_arbiter.sv
// Two-port round-robin arbiter in front of a DDR3 command interface.
// The winner's command fields are latched and presented until the controller acks.
module ddr_access_arbiter #(
    parameter int ADDR_W  = 28,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 4095
) (
    input  logic              i_ddr3_sclk,
    input  logic              i_rst_n,
    input  logic [1:0]        i_req,
    input  logic [1:0]        i_req_wr_rdn,
    input  logic [ADDR_W-1:0] i_req_addr0,
    input  logic [ADDR_W-1:0] i_req_addr1,
    input  logic [LEN_W-1:0]  i_req_len0,
    input  logic [LEN_W-1:0]  i_req_len1,
    output logic [1:0]        o_grant,
    output logic [1:0]        o_done,
    output logic [1:0]        o_err,
    output logic              o_ddr3_cmd_vld,
    output logic              o_ddr3_wr_rdn,
    output logic [ADDR_W-1:0] o_ddr3_addr,
    output logic [LEN_W-1:0]  o_ddr3_len,
    input  logic              i_ddr3_ack,
    input  logic              i_ddr3_op_done
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    // The last WAIT_DONE cycle that may still see op_done before the error fires.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic               last_r;
    logic               last_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic               sel_port_s;
    logic [1:0]         sel_onehot_s;
    logic [LEN_W-1:0]   sel_len_s;
    logic               len_ok_s;
    logic               start_s;
    logic               timeout_s;
    logic               load_s;
    logic [1:0]         grant_nxt_s;
    logic [1:0]         done_nxt_s;
    logic [1:0]         err_nxt_s;
    logic               cmd_vld_nxt_s;

    // Round-robin pick: on a tie the port not granted last wins.
    always_comb begin
        sel_port_s = 1'b0;
        if (i_req == 2'b11) begin
            sel_port_s = ~last_r;
        end else if (i_req[1]) begin
            sel_port_s = 1'b1;
        end else begin
            sel_port_s = 1'b0;
        end
    end

    assign sel_onehot_s = sel_port_s ? 2'b10 : 2'b01;
    assign sel_len_s    = sel_port_s ? i_req_len1 : i_req_len0;
    assign len_ok_s     = (sel_len_s != {LEN_W{1'b0}});
    // Arbitration is held off while a done/err pulse is out, giving one idle bubble.
    assign start_s      = (state_r == ST_IDLE) && (i_req != 2'b00)
                          && (o_done == 2'b00) && (o_err == 2'b00);
    assign timeout_s    = (cnt_r == CNT_LAST);

    // State register.
    always_ff @(posedge i_ddr3_sclk) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s && len_ok_s) begin
                    state_nxt_s = ST_CMD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (i_ddr3_ack && i_ddr3_op_done) begin
                    state_nxt_s = ST_IDLE;
                end else if (i_ddr3_ack) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_CMD;
                end
            end
            ST_WAIT: begin
                if (i_ddr3_op_done || timeout_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, pointer and timeout counter.
    always_comb begin
        grant_nxt_s   = o_grant;
        cmd_vld_nxt_s = o_ddr3_cmd_vld;
        done_nxt_s    = 2'b00;
        err_nxt_s     = 2'b00;
        last_nxt_s    = last_r;
        cnt_nxt_s     = cnt_r;
        load_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_s && len_ok_s) begin
                    grant_nxt_s   = sel_onehot_s;
                    cmd_vld_nxt_s = 1'b1;
                    load_s        = 1'b1;
                end else if (start_s) begin
                    err_nxt_s  = sel_onehot_s;
                    last_nxt_s = sel_port_s;
                end else begin
                    grant_nxt_s = 2'b00;
                end
            end
            ST_CMD: begin
                if (i_ddr3_ack) begin
                    cmd_vld_nxt_s = 1'b0;
                    cnt_nxt_s     = {CNT_W{1'b0}};
                    if (i_ddr3_op_done) begin
                        grant_nxt_s = 2'b00;
                        done_nxt_s  = o_grant;
                        last_nxt_s  = o_grant[1];
                    end else begin
                        grant_nxt_s = o_grant;
                    end
                end else begin
                    cmd_vld_nxt_s = 1'b1;
                end
            end
            ST_WAIT: begin
                cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                if (i_ddr3_op_done) begin
                    grant_nxt_s = 2'b00;
                    done_nxt_s  = o_grant;
                    last_nxt_s  = o_grant[1];
                end else if (timeout_s) begin
                    grant_nxt_s = 2'b00;
                    err_nxt_s   = o_grant;
                    last_nxt_s  = o_grant[1];
                end else begin
                    grant_nxt_s = o_grant;
                end
            end
            default: begin
                grant_nxt_s   = 2'b00;
                cmd_vld_nxt_s = 1'b0;
            end
        endcase
    end

    // Output, pointer, counter and command-field registers.
    always_ff @(posedge i_ddr3_sclk) begin
        if (!i_rst_n) begin
            o_grant        <= 2'b00;
            o_done         <= 2'b00;
            o_err          <= 2'b00;
            o_ddr3_cmd_vld <= 1'b0;
            o_ddr3_wr_rdn  <= 1'b0;
            o_ddr3_addr    <= {ADDR_W{1'b0}};
            o_ddr3_len     <= {LEN_W{1'b0}};
            cnt_r          <= {CNT_W{1'b0}};
            last_r         <= 1'b1;
        end else begin
            o_grant        <= grant_nxt_s;
            o_done         <= done_nxt_s;
            o_err          <= err_nxt_s;
            o_ddr3_cmd_vld <= cmd_vld_nxt_s;
            cnt_r          <= cnt_nxt_s;
            last_r         <= last_nxt_s;
            if (load_s) begin
                o_ddr3_wr_rdn <= sel_port_s ? i_req_wr_rdn[1] : i_req_wr_rdn[0];
                o_ddr3_addr   <= sel_port_s ? i_req_addr1 : i_req_addr0;
                o_ddr3_len    <= sel_len_s;
            end
        end
    end

endmodule

// File: tb/tb_ddr_access_arbiter.sv
// Directed bench for ddr_access_arbiter: a vector table plus hand-written
// sequences for single write, contention, timeout and mid-transaction reset.
module tb_ddr_access_arbiter;

    localparam int AW = 28;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    req, wr;
    logic [AW-1:0] a0, a1;
    logic [LW-1:0] l0, l1;
    logic          ack, opd;

    logic [1:0]    grant, done, err;
    logic          cv, dwr;
    logic [AW-1:0] daddr;
    logic [LW-1:0] dlen;

    logic [1:0]    t_grant, t_done, t_err;
    logic          t_cv, t_dwr;
    logic [AW-1:0] t_addr;
    logic [LW-1:0] t_len;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ddr_access_arbiter #(.ADDR_W(AW), .LEN_W(LW)) dut (
        .i_ddr3_sclk(clk), .i_rst_n(rst_n), .i_req(req), .i_req_wr_rdn(wr),
        .i_req_addr0(a0), .i_req_addr1(a1), .i_req_len0(l0), .i_req_len1(l1),
        .o_grant(grant), .o_done(done), .o_err(err), .o_ddr3_cmd_vld(cv),
        .o_ddr3_wr_rdn(dwr), .o_ddr3_addr(daddr), .o_ddr3_len(dlen),
        .i_ddr3_ack(ack), .i_ddr3_op_done(opd)
    );

    ddr_access_arbiter #(.ADDR_W(AW), .LEN_W(LW), .TIMEOUT(8)) dut_to (
        .i_ddr3_sclk(clk), .i_rst_n(rst_n), .i_req(req), .i_req_wr_rdn(wr),
        .i_req_addr0(a0), .i_req_addr1(a1), .i_req_len0(l0), .i_req_len1(l1),
        .o_grant(t_grant), .o_done(t_done), .o_err(t_err), .o_ddr3_cmd_vld(t_cv),
        .o_ddr3_wr_rdn(t_dwr), .o_ddr3_addr(t_addr), .o_ddr3_len(t_len),
        .i_ddr3_ack(ack), .i_ddr3_op_done(opd)
    );

    typedef struct {
        logic [1:0]    req, wr;
        logic [AW-1:0] a0, a1;
        logic [LW-1:0] l0, l1;
        logic          ack, opd;
        logic [1:0]    g, d, e;
        logic          cv, dwr;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        req = 2'b00; wr = 2'b00; a0 = '0; a1 = '0; l0 = '0; l1 = '0;
        ack = 1'b0; opd = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_grant", {30'd0, grant}, 32'd0);
        chk("rst_cmd_vld", {31'd0, cv}, 32'd0);
        chk("rst_to_grant", {30'd0, t_grant}, 32'd0);
        rst_n = 1'b1;
    endtask

    task automatic drive(input vec_t v);
        req = v.req; wr = v.wr; a0 = v.a0; a1 = v.a1;
        l0 = v.l0; l1 = v.l1; ack = v.ack; opd = v.opd;
    endtask

    initial begin
        // Fields: req, wr, a0, a1, l0, l1, ack, opd | grant, done, err, cmd_vld, wr_rdn, addr, len
        tbl[0]  = '{2'b10, 2'b00, 28'h0,   28'h0,    8'd0, 8'd0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 28'h0,    8'd0};
        tbl[1]  = '{2'b00, 2'b00, 28'h0,   28'h0,    8'd0, 8'd0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 28'h0,    8'd0};
        tbl[2]  = '{2'b01, 2'b00, 28'h0AB, 28'h0,    8'd4, 8'd0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 28'h0,    8'd0};
        tbl[3]  = '{2'b00, 2'b01, 28'hFFF, 28'h0,    8'd9, 8'd0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 28'h0AB,  8'd4};
        tbl[4]  = '{2'b00, 2'b01, 28'hFFF, 28'h0,    8'd9, 8'd0, 1'b1, 1'b1, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 28'h0AB,  8'd4};
        tbl[5]  = '{2'b11, 2'b10, 28'hFFF, 28'h1234, 8'd9, 8'd2, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 28'h0,    8'd0};
        tbl[6]  = '{2'b11, 2'b10, 28'hFFF, 28'h1234, 8'd9, 8'd2, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 28'h0,    8'd0};
        tbl[7]  = '{2'b00, 2'b10, 28'hFFF, 28'h1234, 8'd9, 8'd2, 1'b1, 1'b0, 2'b10, 2'b00, 2'b00, 1'b1, 1'b1, 28'h1234, 8'd2};
        tbl[8]  = '{2'b00, 2'b00, 28'h0,   28'h0,    8'd0, 8'd0, 1'b1, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 28'h0,    8'd0};
        tbl[9]  = '{2'b00, 2'b00, 28'h0,   28'h0,    8'd0, 8'd0, 1'b1, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 28'h0,    8'd0};
        tbl[10] = '{2'b00, 2'b00, 28'h0,   28'h0,    8'd0, 8'd0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 28'h0,    8'd0};

        // Vector table: zero length, stray op_done, ack+op_done together, bubble, tie-break.
        reset_dut();
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("tbl%0d_grant", i), {30'd0, grant}, {30'd0, tbl[i].g});
            chk($sformatf("tbl%0d_done", i), {30'd0, done}, {30'd0, tbl[i].d});
            chk($sformatf("tbl%0d_err", i), {30'd0, err}, {30'd0, tbl[i].e});
            chk($sformatf("tbl%0d_cmd_vld", i), {31'd0, cv}, {31'd0, tbl[i].cv});
            if (tbl[i].cv) begin
                chk($sformatf("tbl%0d_wr_rdn", i), {31'd0, dwr}, {31'd0, tbl[i].dwr});
                chk($sformatf("tbl%0d_addr", i), {4'd0, daddr}, {4'd0, tbl[i].addr});
                chk($sformatf("tbl%0d_len", i), {24'd0, dlen}, {24'd0, tbl[i].len});
            end
            drive(tbl[i]);
            @(negedge clk);
        end

        // Single write: ack in cycle 3, op_done in cycle 20.
        reset_dut();
        for (int k = 0; k <= 22; k++) begin
            chk($sformatf("wr%0d_grant", k), {30'd0, grant}, (k >= 1 && k <= 20) ? 32'd1 : 32'd0);
            chk($sformatf("wr%0d_cmd_vld", k), {31'd0, cv}, (k >= 1 && k <= 3) ? 32'd1 : 32'd0);
            chk($sformatf("wr%0d_done", k), {30'd0, done}, (k == 21) ? 32'd1 : 32'd0);
            chk($sformatf("wr%0d_err", k), {30'd0, err}, 32'd0);
            if (k >= 1 && k <= 3) begin
                chk($sformatf("wr%0d_addr", k), {4'd0, daddr}, 32'h100);
                chk($sformatf("wr%0d_len", k), {24'd0, dlen}, 32'd16);
                chk($sformatf("wr%0d_wr_rdn", k), {31'd0, dwr}, 32'd1);
            end
            req = (k <= 3) ? 2'b01 : 2'b00;
            wr = 2'b01; a0 = 28'h100; l0 = 8'd16;
            ack = (k == 3); opd = (k == 20);
            @(negedge clk);
        end

        // Contention: both ports requesting; each transaction takes 4 cycles incl. bubble.
        reset_dut();
        a0 = 28'h10; a1 = 28'h20; l0 = 8'd1; l1 = 8'd1; wr = 2'b00;
        for (int k = 0; k <= 12; k++) begin
            int ph;
            int t;
            logic [1:0] port;
            ph = (k + 3) % 4;
            t = (k + 3) / 4 - 1;
            port = (t % 2 == 0) ? 2'b01 : 2'b10;
            chk($sformatf("rr%0d_grant", k), {30'd0, grant}, (ph < 2) ? {30'd0, port} : 32'd0);
            chk($sformatf("rr%0d_done", k), {30'd0, done}, (ph == 2) ? {30'd0, port} : 32'd0);
            chk($sformatf("rr%0d_err", k), {30'd0, err}, 32'd0);
            req = 2'b11;
            ack = (ph == 0);
            opd = (ph == 1);
            @(negedge clk);
        end

        // Timeout on the TIMEOUT=8 instance: WAIT_DONE entered in cycle 2, error in cycle 10.
        reset_dut();
        a0 = 28'h200; wr = 2'b01; l0 = 8'd5;
        for (int k = 0; k <= 12; k++) begin
            chk($sformatf("to%0d_grant", k), {30'd0, t_grant}, (k >= 1 && k <= 9) ? 32'd1 : 32'd0);
            chk($sformatf("to%0d_err", k), {30'd0, t_err}, (k == 10) ? 32'd1 : 32'd0);
            chk($sformatf("to%0d_done", k), {30'd0, t_done}, 32'd0);
            chk($sformatf("to%0d_cmd_vld", k), {31'd0, t_cv}, (k == 1) ? 32'd1 : 32'd0);
            chk($sformatf("to%0d_main_grant", k), {30'd0, grant}, (k >= 1) ? 32'd1 : 32'd0);
            req = (k == 0) ? 2'b01 : 2'b00;
            ack = (k == 1);
            opd = 1'b0;
            @(negedge clk);
        end

        // Reset while the default instance sits in WAIT_DONE.
        rst_n = 1'b0;
        @(negedge clk);
        chk("mr_grant", {30'd0, grant}, 32'd0);
        chk("mr_done", {30'd0, done}, 32'd0);
        chk("mr_err", {30'd0, err}, 32'd0);
        chk("mr_cmd_vld", {31'd0, cv}, 32'd0);
        chk("mr_wr_rdn", {31'd0, dwr}, 32'd0);
        chk("mr_addr", {4'd0, daddr}, 32'd0);
        chk("mr_len", {24'd0, dlen}, 32'd0);
        chk("mr_to_addr", {4'd0, t_addr}, 32'd0);
        chk("mr_to_len", {24'd0, t_len}, 32'd0);
        chk("mr_to_wr_rdn", {31'd0, t_dwr}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr1_done", {30'd0, done}, 32'd0);
        chk("mr1_err", {30'd0, err}, 32'd0);
        chk("mr1_grant", {30'd0, grant}, 32'd0);
        req = 2'b10; wr = 2'b00; a1 = 28'h55; l1 = 8'd3;
        @(negedge clk);
        chk("mr2_grant", {30'd0, grant}, 32'd2);
        chk("mr2_cmd_vld", {31'd0, cv}, 32'd1);
        chk("mr2_addr", {4'd0, daddr}, 32'h55);
        chk("mr2_len", {24'd0, dlen}, 32'd3);
        chk("mr2_wr_rdn", {31'd0, dwr}, 32'd0);
        req = 2'b00; ack = 1'b1;
        @(negedge clk);
        chk("mr3_cmd_vld", {31'd0, cv}, 32'd0);
        chk("mr3_grant", {30'd0, grant}, 32'd2);
        ack = 1'b0; opd = 1'b1;
        @(negedge clk);
        chk("mr4_done", {30'd0, done}, 32'd2);
        chk("mr4_grant", {30'd0, grant}, 32'd0);
        opd = 1'b0;
        @(negedge clk);
        chk("mr5_done", {30'd0, done}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
